// File: rtl/booth2_pkg.sv
// rtl/booth2_pkg.sv - shared Booth code constants, state encoding and helpers
package booth2_pkg;

  // Radix-4 Booth triplets {b[2i+1], b[2i], b[2i-1]} and the digit each selects
  localparam logic [2:0] CODE_ZERO0 = 3'b000;  //  0
  localparam logic [2:0] CODE_P1A   = 3'b001;  // +1
  localparam logic [2:0] CODE_P1B   = 3'b010;  // +1
  localparam logic [2:0] CODE_P2A   = 3'b011;  // +2
  localparam logic [2:0] CODE_N2A   = 3'b100;  // -2
  localparam logic [2:0] CODE_N1A   = 3'b101;  // -1
  localparam logic [2:0] CODE_N1B   = 3'b110;  // -1
  localparam logic [2:0] CODE_ZERO1 = 3'b111;  //  0

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // A triplet selects a zero partial product when all three bits agree
  function automatic logic is_zero_code(input logic [2:0] code);
    return (code == CODE_ZERO0) || (code == CODE_ZERO1);
  endfunction

endpackage

// File: rtl/booth2_code_classify.sv
// rtl/booth2_code_classify.sv - decodes a Booth triplet into zero/neg/two flags
module booth2_code_classify
  import booth2_pkg::*;
(
  input  logic [2:0] code,
  output logic       zero,
  output logic       neg,
  output logic       two
);

  // Flags describe the digit: zero product, negated multiplicand, doubled multiplicand
  always_comb begin
    zero = is_zero_code(code);
    neg  = code[2] && !zero;
    two  = (code == CODE_P2A) || (code == CODE_N2A);
  end

endmodule

// File: rtl/booth2_code_seq.sv
// rtl/booth2_code_seq.sv - serial radix-4 Booth code producer (option: BOOTH2_ZERO_SKIP_EN)
module booth2_code_seq
  import booth2_pkg::*;
#(
  parameter  int WIDTH  = 16,          // must be even and at least 4
  localparam int GROUPS = WIDTH / 2,
  localparam int IDXW   = $clog2(GROUPS)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] B,
  output logic             code_valid,
  input  logic             code_ready,
  output logic [2:0]       code_3bit,
  output logic [IDXW-1:0]  code_idx,
  output logic             code_last,
  output logic             busy
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(GROUPS - 1);

  state_t          state;
  logic [WIDTH:0]  sreg;      // {B, b[-1]=0}; low three bits are the current triplet
  logic [IDXW-1:0] idx;
  logic            at_last;
  logic            skip;
  logic            fire;
  logic            accept;

  assign busy    = (state == EMIT);
  assign at_last = (idx == LAST_IDX);

`ifdef BOOTH2_ZERO_SKIP_EN
  logic grp_zero;

  booth2_code_classify u_classify (
    .code (sreg[2:0]),
    .zero (grp_zero),
    .neg  (),
    .two  ()
  );

  // Zero-product groups are stepped over silently; the last group always shows
  assign skip = busy && grp_zero && !at_last;
`else
  assign skip = 1'b0;
`endif

  assign code_valid = busy && !skip;
  assign code_3bit  = sreg[2:0];
  assign code_idx   = idx;
  assign code_last  = busy && at_last;
  assign fire       = code_valid && code_ready;
  // A new operand may load during the final handshake so streams run without a bubble
  assign in_ready   = !busy || (code_last && code_ready);
  assign accept     = in_valid && in_ready;

  // Load, shift by one group per handshake (or skip), and retire after the last group
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      sreg  <= '0;
      idx   <= '0;
    end else if (accept) begin
      state <= EMIT;
      sreg  <= {B, 1'b0};
      idx   <= '0;
    end else if (fire && at_last) begin
      state <= IDLE;
      sreg  <= '0;
      idx   <= '0;
    end else if (fire || skip) begin
      sreg  <= {{2{sreg[WIDTH]}}, sreg[WIDTH:2]};
      idx   <= idx + IDXW'(1);
    end
  end

endmodule
